// File: rtl/axi_slave_reg_bridge.sv
// rtl/axi_slave_reg_bridge.sv - AXI4 slave to single-beat register bus bridge
//
// Purpose: accepts one AXI4 read or write burst at a time from the interconnect
// and replays it as single-beat request/response transfers on the register bus.
// Handles window decode, INCR/FIXED address stepping, ID echo and error merging.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   axi_mosi        - AXI4 master-to-slave channels (AW, W, B-ready, AR, R-ready)
//   axi_miso        - AXI4 slave-to-master channels (AW/W/AR ready, B, R)
//   reg_req_*       - register request (valid/ready, we, offset addr, wdata, wstrb)
//   reg_rsp_*       - register response pulse with read data and error flag

package amba_axi_pkg;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ID_WIDTH   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]     awid;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic                        awvalid;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wlast;
    logic                        wvalid;
    logic                        bready;
    logic [AXI_ID_WIDTH-1:0]     arid;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arvalid;
    logic                        rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                        awready;
    logic                        wready;
    logic [AXI_ID_WIDTH-1:0]     bid;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        arready;
    logic [AXI_ID_WIDTH-1:0]     rid;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic                        rvalid;
  } s_axi_miso_t;
endpackage

module axi_slave_reg_bridge #(
  parameter logic [amba_axi_pkg::AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned WINDOW_SIZE    = 'h1000,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  amba_axi_pkg::s_axi_mosi_t               axi_mosi,
  output amba_axi_pkg::s_axi_miso_t               axi_miso,
  output logic                                    reg_req_valid,
  input  logic                                    reg_req_ready,
  output logic                                    reg_req_we,
  output logic [amba_axi_pkg::AXI_ADDR_WIDTH-1:0] reg_req_addr,
  output logic [DATA_WIDTH-1:0]                   reg_req_wdata,
  output logic [DATA_WIDTH/8-1:0]                 reg_req_wstrb,
  input  logic                                    reg_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                   reg_rsp_rdata,
  input  logic                                    reg_rsp_err
);
  import amba_axi_pkg::*;

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_DATA
  } state_t;

  state_t                  state_q, state_d;
  logic                    prio_wr_q;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [AW-1:0]           addr_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [7:0]              cnt_q;
  logic [1:0]              txn_err_q;
  logic [1:0]              resp_acc_q;
  logic                    last_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;
  logic [TW-1:0]           tcnt_q;

  logic          aw_grant, ar_grant, wready, req_valid, bvalid, rvalid;
  logic          timeout, beat_done, beat_err, w_last_beat, early_wlast;
  logic [1:0]    beat_code, beat_status;
  logic [AW-1:0] next_addr;

  // Widened by one bit so a window ending at the top of the address space
  // does not wrap.
  function automatic logic in_window(input logic [AW-1:0] a);
    logic [AW:0] lo, hi;
    lo = {1'b0, BASE_ADDR};
    hi = lo + (AW+1)'(WINDOW_SIZE);
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  function automatic logic [1:0] decode(input logic [AW-1:0] a, input logic [1:0] b);
    if (!in_window(a))     return RESP_DECERR;
    if (b == BURST_WRAP)   return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // Encodings order as OKAY < SLVERR < DECERR, so the worst is the larger.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Once a beat leaves the window the sticky txn_err_q keeps later beats DECERR.
  assign beat_code   = in_window(addr_q) ? txn_err_q : RESP_DECERR;
  assign beat_err    = (beat_code != RESP_OKAY);
  assign timeout     = (tcnt_q == TW'(TIMEOUT_CYCLES));
  assign beat_done   = reg_rsp_valid || timeout;
  assign beat_status = (!reg_rsp_valid || reg_rsp_err) ? RESP_SLVERR : RESP_OKAY;
  assign w_last_beat = axi_mosi.wlast || (cnt_q == 8'd0);
  assign early_wlast = axi_mosi.wlast && (cnt_q != 8'd0);
  assign next_addr   = (burst_q == BURST_FIXED) ? addr_q : addr_q + (AW'(1) << size_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    aw_grant  = 1'b0;
    ar_grant  = 1'b0;
    wready    = 1'b0;
    req_valid = 1'b0;
    bvalid    = 1'b0;
    rvalid    = 1'b0;
    case (state_q)
      IDLE: begin
        // Contention is resolved by prio_wr_q; a lone request is always granted.
        if (!rst) begin
          if (axi_mosi.awvalid && (!axi_mosi.arvalid || prio_wr_q)) aw_grant = 1'b1;
          else if (axi_mosi.arvalid)                                ar_grant = 1'b1;
        end
        if (aw_grant)      state_d = WR_DATA;
        else if (ar_grant) state_d = RD_REQ;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (axi_mosi.wvalid) begin
          if (!beat_err)        state_d = WR_REQ;
          else if (w_last_beat) state_d = WR_RESP;
        end
      end
      WR_REQ: begin
        req_valid = 1'b1;
        if (reg_req_ready) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (beat_done) state_d = last_q ? WR_RESP : WR_DATA;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (axi_mosi.bready) state_d = IDLE;
      end
      RD_REQ: begin
        // Errored beats skip the register bus and go straight to the R channel.
        if (beat_err) state_d = RD_DATA;
        else begin
          req_valid = 1'b1;
          if (reg_req_ready) state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (beat_done) state_d = RD_DATA;
      end
      RD_DATA: begin
        rvalid = 1'b1;
        if (axi_mosi.rready) state_d = (cnt_q == 8'd0) ? IDLE : RD_REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_wr_q  <= 1'b1;
      id_q       <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
      txn_err_q  <= RESP_OKAY;
      resp_acc_q <= RESP_OKAY;
      last_q     <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      tcnt_q     <= '0;
    end else begin
      // Zero outside the WAIT states, so it is clear on every WAIT entry.
      if (state_q == WR_WAIT || state_q == RD_WAIT) begin
        if (!timeout) tcnt_q <= tcnt_q + TW'(1);
      end else begin
        tcnt_q <= '0;
      end

      case (state_q)
        IDLE: begin
          if (aw_grant) begin
            id_q       <= axi_mosi.awid;
            addr_q     <= axi_mosi.awaddr;
            size_q     <= axi_mosi.awsize;
            burst_q    <= axi_mosi.awburst;
            cnt_q      <= axi_mosi.awlen;
            txn_err_q  <= decode(axi_mosi.awaddr, axi_mosi.awburst);
            resp_acc_q <= RESP_OKAY;
            if (axi_mosi.arvalid) prio_wr_q <= ~prio_wr_q;
          end else if (ar_grant) begin
            id_q      <= axi_mosi.arid;
            addr_q    <= axi_mosi.araddr;
            size_q    <= axi_mosi.arsize;
            burst_q   <= axi_mosi.arburst;
            cnt_q     <= axi_mosi.arlen;
            txn_err_q <= decode(axi_mosi.araddr, axi_mosi.arburst);
            if (axi_mosi.awvalid) prio_wr_q <= ~prio_wr_q;
          end
        end
        WR_DATA: begin
          if (axi_mosi.wvalid) begin
            resp_acc_q <= worst(worst(resp_acc_q, beat_code),
                                early_wlast ? RESP_SLVERR : RESP_OKAY);
            if (beat_err) begin
              txn_err_q <= beat_code;
              if (!w_last_beat) begin
                cnt_q  <= cnt_q - 8'd1;
                addr_q <= next_addr;
              end
            end else begin
              wdata_q <= axi_mosi.wdata;
              wstrb_q <= axi_mosi.wstrb;
              last_q  <= w_last_beat;
            end
          end
        end
        WR_WAIT: begin
          if (beat_done) begin
            resp_acc_q <= worst(resp_acc_q, beat_status);
            if (!last_q) begin
              cnt_q  <= cnt_q - 8'd1;
              addr_q <= next_addr;
            end
          end
        end
        RD_REQ: begin
          if (beat_err) begin
            rdata_q   <= '0;
            rresp_q   <= beat_code;
            txn_err_q <= beat_code;
          end
        end
        RD_WAIT: begin
          if (beat_done) begin
            rdata_q <= reg_rsp_valid ? reg_rsp_rdata : '0;
            rresp_q <= beat_status;
          end
        end
        RD_DATA: begin
          if (axi_mosi.rready && cnt_q != 8'd0) begin
            cnt_q  <= cnt_q - 8'd1;
            addr_q <= next_addr;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    axi_miso         = '0;
    axi_miso.awready = aw_grant;
    axi_miso.arready = ar_grant;
    axi_miso.wready  = wready;
    axi_miso.bvalid  = bvalid;
    axi_miso.bid     = id_q;
    axi_miso.bresp   = resp_acc_q;
    axi_miso.rvalid  = rvalid;
    axi_miso.rid     = id_q;
    axi_miso.rdata   = rdata_q;
    axi_miso.rresp   = rresp_q;
    axi_miso.rlast   = rvalid && (cnt_q == 8'd0);
  end

  assign reg_req_valid = req_valid;
  assign reg_req_we    = (state_q == WR_REQ);
  assign reg_req_addr  = addr_q - BASE_ADDR;
  assign reg_req_wdata = wdata_q;
  assign reg_req_wstrb = wstrb_q;

endmodule

// File: tb/tb_axi_slave_reg_bridge.sv
// tb/tb_axi_slave_reg_bridge.sv - scoreboard bench for axi_slave_reg_bridge
module tb_axi_slave_reg_bridge;
  import amba_axi_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int WIN    = 'h1000;
  localparam int TO     = 20;
  localparam int BUDGET = 200;

  logic        clk = 1'b0;
  logic        rst;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  logic        reg_req_valid, reg_req_ready, reg_req_we;
  logic [31:0] reg_req_addr, reg_req_wdata, reg_rsp_rdata;
  logic [3:0]  reg_req_wstrb;
  logic        reg_rsp_valid, reg_rsp_err;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } req_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;

  req_t   exp_req[$];
  rbeat_t exp_r[$];
  b_t     exp_b[$];

  int tests_run = 0, tests_failed = 0, cyc = 0, req_seen = 0;
  bit no_rsp = 1'b0, err_once = 1'b0;
  bit pend = 1'b0, pend_err = 1'b0;
  logic [31:0] pend_data = '0;

  axi_slave_reg_bridge #(
    .BASE_ADDR(BASE), .WINDOW_SIZE(WIN), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .axi_mosi(mosi), .axi_miso(miso),
    .reg_req_valid(reg_req_valid), .reg_req_ready(reg_req_ready), .reg_req_we(reg_req_we),
    .reg_req_addr(reg_req_addr), .reg_req_wdata(reg_req_wdata), .reg_req_wstrb(reg_req_wstrb),
    .reg_rsp_valid(reg_rsp_valid), .reg_rsp_rdata(reg_rsp_rdata), .reg_rsp_err(reg_rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Register-bus model: always ready, answers one cycle after each accept.
  initial begin
    reg_req_ready = 1'b1;
    reg_rsp_valid = 1'b0;
    reg_rsp_err   = 1'b0;
    reg_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        reg_rsp_valid = 1'b1; reg_rsp_rdata = pend_data; reg_rsp_err = pend_err; pend = 1'b0;
      end else begin
        reg_rsp_valid = 1'b0; reg_rsp_rdata = '0; reg_rsp_err = 1'b0;
      end
      if (!rst && reg_req_valid) begin
        req_t e;
        req_seen++;
        tests_run++;
        if (exp_req.size() == 0) begin
          tests_failed++;
          $display("FAIL reg_req_unexpected: got we=%b addr=%h, required none", reg_req_we, reg_req_addr);
        end else begin
          e = exp_req.pop_front();
          if ({reg_req_we, reg_req_addr} !== {e.we, e.addr} ||
              (e.we && {reg_req_wdata, reg_req_wstrb} !== {e.wdata, e.wstrb})) begin
            tests_failed++;
            $display("FAIL reg_req: got we=%b addr=%h wdata=%h wstrb=%h, required we=%b addr=%h wdata=%h wstrb=%h",
                     reg_req_we, reg_req_addr, reg_req_wdata, reg_req_wstrb, e.we, e.addr, e.wdata, e.wstrb);
          end
        end
        pend      = !no_rsp;
        pend_data = rd_pat(reg_req_addr);
        pend_err  = err_once;
        err_once  = 1'b0;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; mosi = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int nbeats, input logic [31:0] wd0,
                           input logic [3:0] ws, output int aw_cyc, output int b_cyc, output int w_hs);
    int n;
    b_t e;
    aw_cyc = -1; b_cyc = -1; w_hs = 0;
    @(negedge clk);
    mosi.awid = id; mosi.awaddr = addr; mosi.awlen = len; mosi.awsize = 3'd2;
    mosi.awburst = burst; mosi.awvalid = 1'b1;
    n = 0; #1;
    while (!miso.awready && n < BUDGET) begin @(negedge clk); #1; n++; end
    if (!miso.awready) begin
      tests_run++; tests_failed++; mosi.awvalid = 1'b0;
      $display("FAIL aw_handshake: got no awready, required within %0d cycles", BUDGET);
      return;
    end
    aw_cyc = cyc;
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      mosi.awvalid = 1'b0;
      mosi.wdata = wd0 + i; mosi.wstrb = ws; mosi.wlast = (i == nbeats - 1); mosi.wvalid = 1'b1;
      n = 0; #1;
      while (!miso.wready && n < BUDGET) begin @(negedge clk); #1; n++; end
      if (!miso.wready) begin
        tests_run++; tests_failed++; mosi.wvalid = 1'b0;
        $display("FAIL w_handshake: got no wready on beat %0d, required within %0d cycles", i, BUDGET);
        return;
      end
      w_hs++;
    end
    @(negedge clk);
    mosi.wvalid = 1'b0; mosi.wlast = 1'b0; mosi.bready = 1'b1;
    n = 0; #1;
    while (!miso.bvalid && n < BUDGET) begin @(negedge clk); #1; n++; end
    tests_run++;
    if (!miso.bvalid) begin
      tests_failed++;
      $display("FAIL b_channel: got no bvalid, required within %0d cycles", BUDGET);
    end else begin
      b_cyc = cyc;
      e = exp_b.pop_front();
      if ({miso.bid, miso.bresp} !== {e.id, e.resp}) begin
        tests_failed++;
        $display("FAIL b_resp: got bid=%h bresp=%b, required bid=%h bresp=%b", miso.bid, miso.bresp, e.id, e.resp);
      end
    end
    @(negedge clk);
    mosi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, output int ar_cyc, output int r_cyc);
    int n;
    rbeat_t e;
    ar_cyc = -1; r_cyc = -1;
    @(negedge clk);
    mosi.arid = id; mosi.araddr = addr; mosi.arlen = len; mosi.arsize = 3'd2;
    mosi.arburst = burst; mosi.arvalid = 1'b1;
    n = 0; #1;
    while (!miso.arready && n < BUDGET) begin @(negedge clk); #1; n++; end
    if (!miso.arready) begin
      tests_run++; tests_failed++; mosi.arvalid = 1'b0;
      $display("FAIL ar_handshake: got no arready, required within %0d cycles", BUDGET);
      return;
    end
    ar_cyc = cyc;
    @(negedge clk);
    mosi.arvalid = 1'b0; mosi.rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0; #1;
      while (!miso.rvalid && n < BUDGET) begin @(negedge clk); #1; n++; end
      tests_run++;
      if (!miso.rvalid) begin
        tests_failed++;
        $display("FAIL r_channel: got no rvalid on beat %0d, required within %0d cycles", i, BUDGET);
        break;
      end
      if (i == 0) r_cyc = cyc;
      e = exp_r.pop_front();
      if ({miso.rid, miso.rdata, miso.rresp, miso.rlast} !== {id, e.data, e.resp, e.last}) begin
        tests_failed++;
        $display("FAIL r_beat%0d: got rid=%h rdata=%h rresp=%b rlast=%b, required rid=%h rdata=%h rresp=%b rlast=%b",
                 i, miso.rid, miso.rdata, miso.rresp, miso.rlast, id, e.data, e.resp, e.last);
      end
      @(negedge clk);
    end
    mosi.rready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; mosi = '0; mosi.awvalid = 1'b1; mosi.arvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({miso.awready, miso.arready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_ready: got awready=%b arready=%b, required 0 0", miso.awready, miso.arready);
    end
    mosi = '0;
    @(negedge clk); #1;
    tests_run++;
    if (miso !== '0 || reg_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got miso=%h req_valid=%b, required 0 0", miso, reg_req_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    int a, b, w;
    exp_req.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF});
    exp_b.push_back('{4'd3, RESP_OKAY});
    axi_write(4'd3, BASE + 32'h10, 8'd0, BURST_INCR, 1, 32'hDEADBEEF, 4'hF, a, b, w);
    tests_run++;
    if (b - a !== 4) begin
      tests_failed++;
      $display("FAIL write_latency: got bvalid %0d cycles after AW, required 4", b - a);
    end
  endtask

  task automatic test_incr_read();
    int a, r, s;
    s = req_seen;
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back('{1'b0, 32'h20 + 4*i, 32'h0, 4'h0});
      exp_r.push_back('{rd_pat(32'h20 + 4*i), RESP_OKAY, i == 3});
    end
    axi_read(4'd7, BASE + 32'h20, 8'd3, BURST_INCR, a, r);
    tests_run++;
    if (req_seen - s !== 4) begin
      tests_failed++;
      $display("FAIL incr_read_reqs: got %0d reg reads, required 4", req_seen - s);
    end
  endtask

  task automatic test_fixed_read();
    int a, r;
    for (int i = 0; i < 2; i++) begin
      exp_req.push_back('{1'b0, 32'h30, 32'h0, 4'h0});
      exp_r.push_back('{rd_pat(32'h30), RESP_OKAY, i == 1});
    end
    axi_read(4'd2, BASE + 32'h30, 8'd1, BURST_FIXED, a, r);
  endtask

  task automatic test_decerr_write();
    int a, b, w, s;
    s = req_seen;
    exp_b.push_back('{4'd4, RESP_DECERR});
    axi_write(4'd4, BASE + WIN, 8'd1, BURST_INCR, 2, 32'h1111_0000, 4'hF, a, b, w);
    tests_run++;
    if (req_seen - s !== 0 || w !== 2) begin
      tests_failed++;
      $display("FAIL decerr_write: got %0d reg reqs and %0d W beats, required 0 and 2", req_seen - s, w);
    end
  endtask

  task automatic test_wrap_read();
    int a, r;
    exp_r.push_back('{32'h0, RESP_SLVERR, 1'b0});
    exp_r.push_back('{32'h0, RESP_SLVERR, 1'b1});
    axi_read(4'd9, BASE + 32'h40, 8'd1, BURST_WRAP, a, r);
  endtask

  task automatic test_arbitration();
    int aw1, b1, w1, ar1, r1, aw2, b2, w2, ar2, r2;
    apply_reset();
    exp_req.push_back('{1'b1, 32'h40, 32'hA0A0_0000, 4'h3});
    exp_req.push_back('{1'b0, 32'h50, 32'h0, 4'h0});
    exp_b.push_back('{4'd1, RESP_OKAY});
    exp_r.push_back('{rd_pat(32'h50), RESP_OKAY, 1'b1});
    fork
      axi_write(4'd1, BASE + 32'h40, 8'd0, BURST_INCR, 1, 32'hA0A0_0000, 4'h3, aw1, b1, w1);
      axi_read(4'd2, BASE + 32'h50, 8'd0, BURST_INCR, ar1, r1);
    join
    tests_run++;
    if (!(aw1 >= 0 && ar1 > aw1)) begin
      tests_failed++;
      $display("FAIL arb_first_pair: got aw cycle %0d ar cycle %0d, required write first", aw1, ar1);
    end
    exp_req.push_back('{1'b0, 32'h54, 32'h0, 4'h0});
    exp_req.push_back('{1'b1, 32'h44, 32'hB0B0_0000, 4'hC});
    exp_r.push_back('{rd_pat(32'h54), RESP_OKAY, 1'b1});
    exp_b.push_back('{4'd5, RESP_OKAY});
    fork
      axi_write(4'd5, BASE + 32'h44, 8'd0, BURST_INCR, 1, 32'hB0B0_0000, 4'hC, aw2, b2, w2);
      axi_read(4'd6, BASE + 32'h54, 8'd0, BURST_INCR, ar2, r2);
    join
    tests_run++;
    if (!(ar2 >= 0 && aw2 > ar2)) begin
      tests_failed++;
      $display("FAIL arb_second_pair: got aw cycle %0d ar cycle %0d, required read first", aw2, ar2);
    end
  endtask

  task automatic test_timeout();
    int a, r;
    no_rsp = 1'b1;
    exp_req.push_back('{1'b0, 32'h70, 32'h0, 4'h0});
    exp_r.push_back('{32'h0, RESP_SLVERR, 1'b1});
    axi_read(4'd8, BASE + 32'h70, 8'd0, BURST_INCR, a, r);
    no_rsp = 1'b0;
    tests_run++;
    if (r - a < TO || r - a > TO + 4) begin
      tests_failed++;
      $display("FAIL timeout_latency: got rvalid %0d cycles after AR, required %0d..%0d", r - a, TO, TO + 4);
    end
  endtask

  task automatic test_err_beat();
    int a, b, w;
    err_once = 1'b1;
    exp_req.push_back('{1'b1, 32'h80, 32'h0000_1000, 4'hF});
    exp_req.push_back('{1'b1, 32'h84, 32'h0000_1001, 4'hF});
    exp_b.push_back('{4'd10, RESP_SLVERR});
    axi_write(4'd10, BASE + 32'h80, 8'd1, BURST_INCR, 2, 32'h0000_1000, 4'hF, a, b, w);
  endtask

  task automatic test_early_wlast();
    int a, b, w;
    exp_req.push_back('{1'b1, 32'h90, 32'h0000_2000, 4'hF});
    exp_req.push_back('{1'b1, 32'h94, 32'h0000_2001, 4'hF});
    exp_b.push_back('{4'd11, RESP_SLVERR});
    axi_write(4'd11, BASE + 32'h90, 8'd3, BURST_INCR, 2, 32'h0000_2000, 4'hF, a, b, w);
  endtask

  task automatic test_reset_mid();
    int n, a, r;
    no_rsp = 1'b1;
    exp_req.push_back('{1'b0, 32'h60, 32'h0, 4'h0});
    @(negedge clk);
    mosi.arid = 4'd5; mosi.araddr = BASE + 32'h60; mosi.arlen = 8'd0; mosi.arsize = 3'd2;
    mosi.arburst = BURST_INCR; mosi.arvalid = 1'b1;
    n = 0; #1;
    while (!miso.arready && n < BUDGET) begin @(negedge clk); #1; n++; end
    tests_run++;
    if (!miso.arready) begin
      tests_failed++;
      $display("FAIL rst_mid_ar: got no arready, required within %0d cycles", BUDGET);
    end
    @(negedge clk);
    mosi.arvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if ({reg_req_valid, miso.rvalid, miso.arready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got req_valid=%b rvalid=%b arready=%b, required 0 0 0",
               reg_req_valid, miso.rvalid, miso.arready);
    end
    rst = 1'b0;
    no_rsp = 1'b0;
    exp_req.push_back('{1'b0, 32'h64, 32'h0, 4'h0});
    exp_r.push_back('{rd_pat(32'h64), RESP_OKAY, 1'b1});
    axi_read(4'd12, BASE + 32'h64, 8'd0, BURST_INCR, a, r);
  endtask

  initial begin
    rst = 1'b1;
    mosi = '0;
    test_reset();
    test_single_write();
    test_incr_read();
    test_fixed_read();
    test_decerr_write();
    test_wrap_read();
    test_arbitration();
    test_timeout();
    test_err_beat();
    test_early_wlast();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_req.size() + exp_r.size() + exp_b.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d/%0d/%0d pending req/r/b, required 0/0/0",
               exp_req.size(), exp_r.size(), exp_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
